// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial_rx oversampling receiver:
// state encoding and default frame geometry.
package serial_rx_pkg;

    localparam int SERIAL_RX_DATA_BITS    = 8;
    localparam int SERIAL_RX_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } serial_rx_state_e;

endpackage

// File: rtl/serial_rx_bit_timer.sv
// Mod-CLKS_PER_BIT bit timer for serial_rx. A synchronous clear restarts
// the count at 0. half_tick marks mid-bit of the start bit and full_tick
// marks mid-bit of every later bit. The count wraps at CLKS_PER_BIT-1.
module serial_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);

    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;

    // Count clk cycles within one serial bit; clear or wrap back to 0.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == FULL_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign half_tick = (cnt_q == HALF_LAST);
    assign full_tick = (cnt_q == FULL_LAST);

endmodule

// File: rtl/serial_rx.sv
// Oversampling serial-frame receiver fed by the upstream single-bit dff.
// It detects the start bit and samples the data bits LSB-first at mid-bit.
// It then checks the stop bit and presents the word on a valid/ready register.
// Optional even parity is compiled in with `define SERIAL_RX_PARITY_EN.
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_BITS    = SERIAL_RX_DATA_BITS,
    parameter int CLKS_PER_BIT = SERIAL_RX_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic                 parity_err_o
`endif
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = PARITY;
`endif
    localparam logic [2:0] S_STOP   = STOP;
    localparam logic [2:0] S_BREAK  = BREAK;

    localparam int            IW       = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic tmr_clr;
    logic half_tick;
    logic full_tick;
    logic start_ok;
    logic take_bit;
    logic stop_seen;
    logic parity_bad;
    logic word_ok;

    serial_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (tmr_clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    // Frame sequencing: decide the next state and the timer and sampling strobes.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d   = state_q;
        tmr_clr   = 1'b0;
        start_ok  = 1'b0;
        take_bit  = 1'b0;
        stop_seen = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmr_clr = 1'b1;
                if (!rx_i) state_d = S_START;
            end
            S_START: begin
                if (half_tick) begin
                    tmr_clr = 1'b1;
                    if (rx_i) begin
                        state_d = S_IDLE;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (full_tick) begin
                    take_bit = 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (full_tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (full_tick) begin
                    stop_seen = 1'b1;
                    state_d   = rx_i ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // A held-low line must rise before a new start bit is accepted.
                tmr_clr = 1'b1;
                if (rx_i) state_d = S_IDLE;
            end
            default: begin
                tmr_clr = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, bit index and data shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            // NOTE: the shift register is a few flops rather than a RAM, so
            // resetting it is cheap and keeps the datapath deterministic.
            shift_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                bit_idx_q <= '0;
            end else if (take_bit) begin
                bit_idx_q          <= bit_idx_q + 1'b1;
                shift_q[bit_idx_q] <= rx_i;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic par_bit_q;
    logic parity_err_q;

    // Capture the parity bit at its mid-bit sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit_q <= 1'b0;
        end else if ((state_q == S_PARITY) && full_tick) begin
            par_bit_q <= rx_i;
        end
    end

    // Even parity: the data bits plus the parity bit must XOR to 0.
    assign parity_bad = ^{shift_q, par_bit_q};

    // Flag a parity mismatch when the stop bit is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= stop_seen && parity_bad;
        end
    end

    assign parity_err_o = parity_err_q;
`else
    assign parity_bad = 1'b0;
`endif

    // A word is delivered only with a good stop bit and, if enabled, good parity.
    assign word_ok = stop_seen && rx_i && !parity_bad;

    // Output register: load, hold or drop the word, and raise the error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_seen && !rx_i;
            overrun_q   <= word_ok && valid_q && !ready_i;
            if (word_ok && (!valid_q || ready_i)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx (DATA_BITS=8, CLKS_PER_BIT=16).
// Frames are generated bit-by-bit from their data. Expected cycles and words
// come from frame arithmetic. A negedge monitor logs output events relative
// to each frame's cycle 0. Build with +define+SERIAL_RX_PARITY_EN for parity.
module tb_serial_rx;

    localparam int N = 8;
    localparam int C = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = C * (N + 2 + PAR);
    localparam int STOP_CYC  = C / 2 + (N + 1 + PAR) * C;
    localparam int OUT_CYC   = STOP_CYC + 1;

    logic         clk     = 1'b0;
    logic         rst     = 1'b0;
    logic         rx_i    = 1'b1;
    logic         ready_i = 1'b1;
    logic [N-1:0] data_o;
    logic         valid_o;
    logic         busy_o;
    logic         frame_err_o;
    logic         overrun_o;
`ifdef SERIAL_RX_PARITY_EN
    logic         parity_err_o;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    int           v_rise_cnt, v_rise_cyc, v_high_cnt;
    int           fe_cnt, fe_cyc, ov_cnt, ov_cyc, pe_cnt, pe_cyc;
    logic [N-1:0] v_rise_data;
    logic         valid_prev = 1'b0;

    serial_rx #(
        .DATA_BITS    (N),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .parity_err_o (parity_err_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle; cycle numbers are relative to t0.
    always @(negedge clk) begin
        if (valid_o && !valid_prev) begin
            v_rise_cnt++;
            v_rise_cyc  = cyc - t0;
            v_rise_data = data_o;
        end
        if (valid_o) v_high_cnt++;
        if (frame_err_o) begin fe_cnt++; fe_cyc = cyc - t0; end
        if (overrun_o)   begin ov_cnt++; ov_cyc = cyc - t0; end
`ifdef SERIAL_RX_PARITY_EN
        if (parity_err_o) begin pe_cnt++; pe_cyc = cyc - t0; end
`endif
        valid_prev = valid_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        v_rise_cnt = 0; v_rise_cyc = -1; v_high_cnt = 0; v_rise_data = '0;
        fe_cnt = 0; fe_cyc = -1; ov_cnt = 0; ov_cyc = -1; pe_cnt = 0; pe_cyc = -1;
    endtask

    // Drive ncyc cycles of a frame: start, data LSB-first, optional parity, stop.
    task automatic send_frame(input logic [N-1:0] d, input logic stop_b,
                              input logic par_b, input int ncyc);
        int slot;
        t0 = cyc;
        for (int c = 0; c < ncyc; c++) begin
            slot = c / C;
            if (slot == 0)                   rx_i = 1'b0;
            else if (slot <= N)              rx_i = d[slot-1];
            else if (PAR == 1 && slot == N + 1) rx_i = par_b;
            else                             rx_i = stop_b;
            step();
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (valid_o !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        total++; if (data_o !== '0)        begin bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
        total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err_o); end
        total++; if (overrun_o !== 1'b0)   begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
        step(); step();
        rst = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_single();
        logic [N-1:0] d;
        d = 8'hA5;
        ready_i = 1'b1;
        clear_mon();
        send_frame(d, 1'b1, ^d, FRAME_LEN);
        rx_i = 1'b1;
        repeat (4) step();
        total++; if (v_rise_cnt !== 1)       begin bad++; $display("FAIL a5_valid_count got=%0d exp=1", v_rise_cnt); end
        total++; if (v_rise_cyc !== OUT_CYC) begin bad++; $display("FAIL a5_valid_cycle got=%0d exp=%0d", v_rise_cyc, OUT_CYC); end
        total++; if (v_rise_data !== d)      begin bad++; $display("FAIL a5_data got=%h exp=%h", v_rise_data, d); end
        total++; if (v_high_cnt !== 1)       begin bad++; $display("FAIL a5_valid_width got=%0d exp=1", v_high_cnt); end
        total++; if (fe_cnt + ov_cnt + pe_cnt !== 0) begin bad++; $display("FAIL a5_err_pulses got=%0d exp=0", fe_cnt + ov_cnt + pe_cnt); end
    endtask

    task automatic test_glitch();
        clear_mon();
        t0 = cyc;
        rx_i = 1'b0;
        repeat (3) step();
        rx_i = 1'b1;
        repeat (2) step();
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL glitch_busy_early got=%b exp=1", busy_o); end
        repeat (5) step();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", busy_o); end
        repeat (FRAME_LEN) step();
        total++; if (v_rise_cnt + fe_cnt !== 0) begin bad++; $display("FAIL glitch_outputs got=%0d exp=0", v_rise_cnt + fe_cnt); end
    endtask

    task automatic test_frame_err();
        logic [N-1:0] d;
        d = 8'h3C;
        ready_i = 1'b1;
        clear_mon();
        send_frame(d, 1'b0, ^d, FRAME_LEN);
        repeat (20) step();
        total++; if (fe_cnt !== 1)       begin bad++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt); end
        total++; if (fe_cyc !== OUT_CYC) begin bad++; $display("FAIL ferr_cycle got=%0d exp=%0d", fe_cyc, OUT_CYC); end
        total++; if (v_rise_cnt !== 0)   begin bad++; $display("FAIL ferr_valid got=%0d exp=0", v_rise_cnt); end
        total++; if (busy_o !== 1'b1)    begin bad++; $display("FAIL ferr_break_busy got=%b exp=1", busy_o); end
        rx_i = 1'b1;
        step();
        total++; if (busy_o !== 1'b0)    begin bad++; $display("FAIL ferr_break_exit got=%b exp=0", busy_o); end
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] d1, d2;
        d1 = 8'h11;
        d2 = 8'h22;
        ready_i = 1'b0;
        clear_mon();
        send_frame(d1, 1'b1, ^d1, FRAME_LEN);
        total++; if (valid_o !== 1'b1 || data_o !== d1) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/%h", valid_o, data_o, d1); end
        send_frame(d2, 1'b1, ^d2, FRAME_LEN);
        rx_i = 1'b1;
        step();
        total++; if (ov_cnt !== 1)       begin bad++; $display("FAIL b2b_overrun_count got=%0d exp=1", ov_cnt); end
        total++; if (ov_cyc !== OUT_CYC) begin bad++; $display("FAIL b2b_overrun_cycle got=%0d exp=%0d", ov_cyc, OUT_CYC); end
        total++; if (data_o !== d1)      begin bad++; $display("FAIL b2b_data_kept got=%h exp=%h", data_o, d1); end
        total++; if (valid_o !== 1'b1)   begin bad++; $display("FAIL b2b_valid_held got=%b exp=1", valid_o); end
        ready_i = 1'b1;
        step();
        total++; if (valid_o !== 1'b0)   begin bad++; $display("FAIL b2b_accept got=%b exp=0", valid_o); end
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] d;
        ready_i = 1'b0;
        d = 8'hC3;
        send_frame(d, 1'b1, ^d, FRAME_LEN);
        rx_i = 1'b1;
        step();
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL rmid_pending got=%b exp=1", valid_o); end
        clear_mon();
        send_frame(8'hFF, 1'b1, 1'b0, 60);
        rst = 1'b0;
        #1;
        total++; if ({valid_o, busy_o, frame_err_o, overrun_o} !== 4'b0) begin bad++; $display("FAIL rmid_ctrl got=%b exp=0000", {valid_o, busy_o, frame_err_o, overrun_o}); end
        total++; if (data_o !== '0) begin bad++; $display("FAIL rmid_data got=%h exp=00", data_o); end
        step(); step();
        rst = 1'b1;
        rx_i = 1'b1;
        ready_i = 1'b1;
        repeat (4) step();
        total++; if (fe_cnt + ov_cnt + pe_cnt + v_rise_cnt !== 0) begin bad++; $display("FAIL rmid_pulses got=%0d exp=0", fe_cnt + ov_cnt + pe_cnt + v_rise_cnt); end
        clear_mon();
        d = 8'h5A;
        send_frame(d, 1'b1, ^d, FRAME_LEN);
        rx_i = 1'b1;
        repeat (3) step();
        total++; if (v_rise_cnt !== 1 || v_rise_cyc !== OUT_CYC) begin bad++; $display("FAIL rmid_next_valid got=%0d@%0d exp=1@%0d", v_rise_cnt, v_rise_cyc, OUT_CYC); end
        total++; if (v_rise_data !== d) begin bad++; $display("FAIL rmid_next_data got=%h exp=%h", v_rise_data, d); end
    endtask

    task automatic test_random();
        logic [N-1:0] d;
        bit           bad_stop;
        int           gap;
        ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d        = N'($urandom);
            bad_stop = ($urandom_range(0, 3) == 0);
            gap      = bad_stop ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            clear_mon();
            send_frame(d, !bad_stop, ^d, FRAME_LEN);
            rx_i = 1'b1;
            repeat (gap) step();
            total++; if (v_rise_cnt !== (bad_stop ? 0 : 1)) begin bad++; $display("FAIL rnd%0d_valid got=%0d exp=%0d", i, v_rise_cnt, bad_stop ? 0 : 1); end
            total++; if (fe_cnt !== (bad_stop ? 1 : 0))     begin bad++; $display("FAIL rnd%0d_frame_err got=%0d exp=%0d", i, fe_cnt, bad_stop ? 1 : 0); end
            if (!bad_stop) begin
                total++; if (v_rise_data !== d) begin bad++; $display("FAIL rnd%0d_data got=%h exp=%h", i, v_rise_data, d); end
            end
        end
        repeat (4) step();
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        ready_i = 1'b1;
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0, FRAME_LEN);
        rx_i = 1'b1;
        repeat (4) step();
        total++; if (pe_cnt !== 1 || pe_cyc !== OUT_CYC) begin bad++; $display("FAIL parity_pulse got=%0d@%0d exp=1@%0d", pe_cnt, pe_cyc, OUT_CYC); end
        total++; if (v_rise_cnt !== 0) begin bad++; $display("FAIL parity_valid got=%0d exp=0", v_rise_cnt); end
        total++; if (fe_cnt !== 0)     begin bad++; $display("FAIL parity_frame_err got=%0d exp=0", fe_cnt); end
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
